// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Signal bundle for the two-master memory arbiter.
//   m0_* / m1_*  : level-request / single-cycle-ack handshake of each bus master
//   gnt, busy    : current owner (one-hot) and transaction-in-progress flag
//   mem_*        : the single shared memory port (strobes, address, data, mask)
// Modports:
//   master : the arbiter's view; it drives acks, read data and the memory port
//   slave  : the environment's view (the two masters plus the memory)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [1:0]  gnt;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_wr_mask;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_data_in;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    input  mem_data_in,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output gnt, busy,
    output mem_addr, mem_data_out, mem_wr_mask, mem_wr, mem_rd
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    output mem_data_in,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  gnt, busy,
    input  mem_addr, mem_data_out, mem_wr_mask, mem_wr, mem_rd
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory port between two masters (m0 = CPU, m1 = DMA/loader) with
// round-robin arbitration, one transaction at a time. Sequences the one-cycle
// mem_rd/mem_wr strobes and waits READ_LAT cycles before returning read data.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : mem_bus_arbiter_if.master (master handshakes + memory port)
// Parameter:
//   READ_LAT : cycles from the mem_rd pulse to valid mem_data_in (>= 1)
// All outputs are registered; each registered output is computed from the
// state occupied at the clock edge, so it becomes visible one cycle later.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);

  localparam int              CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;       // 1 = m1 owns the transaction
  logic             we_q, we_d;
  logic             last_m1_q, last_m1_d;   // 1 = m1 was granted most recently
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_data_out_q, mem_data_out_d;
  logic [3:0]       mem_wr_mask_q, mem_wr_mask_d;
  logic             mem_wr_q, mem_wr_d;
  logic             mem_rd_q, mem_rd_d;
  logic             m0_ack_q, m0_ack_d;
  logic             m1_ack_q, m1_ack_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;

  // Arbitration: a lone requester wins; on conflict the master not granted
  // last wins. last_m1_q resets to 1 so the first conflict goes to m0.
  logic        any_req;
  logic        pick_m1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wmask;

  assign any_req   = bus.m0_req | bus.m1_req;
  assign pick_m1   = bus.m1_req & (~bus.m0_req | ~last_m1_q);
  assign sel_we    = pick_m1 ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
  assign sel_wmask = pick_m1 ? bus.m1_wmask : bus.m0_wmask;

  // State and output registers.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      last_m1_q      <= 1'b1;
      gnt_q          <= 2'b00;
      busy_q         <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      mem_wr_mask_q  <= 4'b0000;
      mem_wr_q       <= 1'b0;
      mem_rd_q       <= 1'b0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      last_m1_q      <= last_m1_d;
      gnt_q          <= gnt_d;
      busy_q         <= busy_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      mem_wr_mask_q  <= mem_wr_mask_d;
      mem_wr_q       <= mem_wr_d;
      mem_rd_q       <= mem_rd_d;
      m0_ack_q       <= m0_ack_d;
      m1_ack_q       <= m1_ack_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
    end
  end

  // Next-state logic and read-latency counter.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. Strobes and acks default low so they
  // are one-cycle pulses; address/data/mask/rdata default to holding.
  always_comb begin
    owner_d        = owner_q;
    we_d           = we_q;
    last_m1_d      = last_m1_q;
    gnt_d          = gnt_q;
    busy_d         = busy_q;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    mem_wr_mask_d  = mem_wr_mask_q;
    mem_wr_d       = 1'b0;
    mem_rd_d       = 1'b0;
    m0_ack_d       = 1'b0;
    m1_ack_d       = 1'b0;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    case (state_q)
      S_IDLE: begin
        gnt_d  = 2'b00;
        busy_d = 1'b0;
        if (any_req) begin
          owner_d        = pick_m1;
          we_d           = sel_we;
          last_m1_d      = pick_m1;
          gnt_d          = pick_m1 ? 2'b10 : 2'b01;
          busy_d         = 1'b1;
          mem_addr_d     = sel_addr;
          mem_data_out_d = sel_wdata;
          mem_wr_mask_d  = sel_we ? sel_wmask : 4'b0000;
        end
      end
      S_ISSUE: begin
        mem_wr_d = we_q;
        mem_rd_d = ~we_q;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) m1_rdata_d = bus.mem_data_in;
          else         m0_rdata_d = bus.mem_data_in;
        end
      end
      S_RESP: begin
        m0_ack_d = ~owner_q;
        m1_ack_d = owner_q;
      end
      default: ;
    endcase
  end

  assign bus.gnt          = gnt_q;
  assign bus.busy         = busy_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_data_out_q;
  assign bus.mem_wr_mask  = mem_wr_mask_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.m0_ack       = m0_ack_q;
  assign bus.m1_ack       = m1_ack_q;
  assign bus.m0_rdata     = m0_rdata_q;
  assign bus.m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter. Two instances: u_dut (READ_LAT=2)
// is tracked every cycle by a transaction-timeline reference model; u_dut_l1
// (READ_LAT=1) repeats the first read scenario with directed checks.
// Inputs are driven on the falling edge; outputs are compared on the falling
// edge. Cycle k below means the values registered at the k-th rising edge,
// with edge 0 being the IDLE edge that samples the request.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack;
  int n_rd;

  mem_bus_arbiter_if bus ();
  mem_bus_arbiter_if bus1 ();

  mem_bus_arbiter #(.READ_LAT(LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_bus_arbiter #(.READ_LAT(1)) u_dut_l1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a transaction is a timeline of offsets from its grant
  // edge (age 0). Strobe at age 1, read capture at age 1+LAT, ack at age 2
  // (write) or 2+LAT (read); the edge after the ack is free to grant again.
  // ---------------------------------------------------------------------------
  bit          m_active;
  int          m_age;
  bit          m_owner;
  bit          m_we;
  bit          m_last;
  logic [1:0]  e_gnt;
  logic        e_busy, e_wr, e_rd;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_mask;
  logic [1:0]  e_ack;
  logic [31:0] e_rdata [2];

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_age    = 0;
      m_owner  = 1'b0;
      m_we     = 1'b0;
      m_last   = 1'b1;
      e_gnt    = 2'b00;
      e_busy   = 1'b0;
      e_wr     = 1'b0;
      e_rd     = 1'b0;
      e_addr   = '0;
      e_wdata  = '0;
      e_mask   = 4'b0000;
      e_ack    = 2'b00;
      e_rdata[0] = '0;
      e_rdata[1] = '0;
    end else begin
      e_wr  = 1'b0;
      e_rd  = 1'b0;
      e_ack = 2'b00;
      if (!m_active) begin
        e_gnt  = 2'b00;
        e_busy = 1'b0;
        if (bus.m0_req || bus.m1_req) begin
          m_owner  = (bus.m0_req && bus.m1_req) ? !m_last : bus.m1_req;
          m_last   = m_owner;
          m_active = 1'b1;
          m_age    = 0;
          m_we     = m_owner ? bus.m1_we : bus.m0_we;
          e_addr   = m_owner ? bus.m1_addr : bus.m0_addr;
          e_wdata  = m_owner ? bus.m1_wdata : bus.m0_wdata;
          e_mask   = m_we ? (m_owner ? bus.m1_wmask : bus.m0_wmask) : 4'b0000;
          e_gnt    = m_owner ? 2'b10 : 2'b01;
          e_busy   = 1'b1;
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          e_wr = m_we;
          e_rd = !m_we;
        end
        if (!m_we && m_age == 1 + LAT) e_rdata[m_owner] = bus.mem_data_in;
        if (m_age == (m_we ? 2 : 2 + LAT)) begin
          e_ack[m_owner] = 1'b1;
          m_active       = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",          32'(bus.gnt),          32'(e_gnt));
      check("busy",         32'(bus.busy),         32'(e_busy));
      check("mem_addr",     bus.mem_addr,          e_addr);
      check("mem_data_out", bus.mem_data_out,      e_wdata);
      check("mem_wr_mask",  32'(bus.mem_wr_mask),  32'(e_mask));
      check("mem_wr",       32'(bus.mem_wr),       32'(e_wr));
      check("mem_rd",       32'(bus.mem_rd),       32'(e_rd));
      check("m0_ack",       32'(bus.m0_ack),       32'(e_ack[0]));
      check("m1_ack",       32'(bus.m1_ack),       32'(e_ack[1]));
      check("m0_rdata",     bus.m0_rdata,          e_rdata[0]);
      check("m1_rdata",     bus.m1_rdata,          e_rdata[1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all inputs are driven from the single initial process)
  // ---------------------------------------------------------------------------
  logic        r_req   [2];
  logic        r_we    [2];
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_mask  [2];
  int          r_wait  [2];

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wmask = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wmask = '0;
    bus.mem_data_in = '0;
    bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_addr = '0; bus1.m0_wdata = '0; bus1.m0_wmask = '0;
    bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_addr = '0; bus1.m1_wdata = '0; bus1.m1_wmask = '0;
    bus1.mem_data_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle of protocol-abiding random masters: hold req and fields until
  // ack, then usually drop req at that edge, sometimes keep it high so it
  // becomes a fresh request. Occasionally scribble on the fields of a
  // pending request and occasionally pulse reset.
  task automatic rand_cycle();
    logic [1:0] ack;
    ack = {bus.m1_ack, bus.m0_ack};
    for (int m = 0; m < 2; m++) begin
      if (r_req[m]) begin
        if (ack[m]) begin
          r_wait[m] = 0;
          if ($urandom_range(0, 3) != 0) r_req[m] = 1'b0;
        end else begin
          r_wait[m]++;
          if (r_wait[m] > 40) begin
            check("ack_timeout", 32'(r_wait[m]), 32'd40);
            r_wait[m] = 0;
          end
          if ($urandom_range(0, 15) == 0) begin
            r_addr[m]  = $urandom();
            r_wdata[m] = $urandom();
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        r_req[m]   = 1'b1;
        r_we[m]    = 1'($urandom_range(0, 1));
        r_addr[m]  = $urandom();
        r_wdata[m] = $urandom();
        r_mask[m]  = 4'($urandom_range(0, 15));
        r_wait[m]  = 0;
      end
    end
    bus.m0_req = r_req[0]; bus.m0_we = r_we[0]; bus.m0_addr = r_addr[0];
    bus.m0_wdata = r_wdata[0]; bus.m0_wmask = r_mask[0];
    bus.m1_req = r_req[1]; bus.m1_we = r_we[1]; bus.m1_addr = r_addr[1];
    bus.m1_wdata = r_wdata[1]; bus.m1_wmask = r_mask[1];
    bus.mem_data_in = $urandom();
    reset = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // NOTE: inputs use blocking assignments on the falling edge, clear of the rising edge.
    reset = 1'b1;
    clear_inputs();
    for (int m = 0; m < 2; m++) begin
      r_req[m] = 1'b0; r_we[m] = 1'b0; r_addr[m] = '0;
      r_wdata[m] = '0; r_mask[m] = '0; r_wait[m] = 0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_gnt",  32'(bus.gnt),  32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // Scenario 1: m0 read of 0xF0000000 on both latency instances.
    bus.m0_req = 1'b1;  bus.m0_we = 1'b0;  bus.m0_addr = 32'hF000_0000;  bus.m0_wmask = 4'hF;
    bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 32'hF000_0000; bus1.m0_wmask = 4'hF;
    for (int k = 0; k <= 5; k++) begin
      bus.mem_data_in  = (k == 3) ? 32'h0000_0013 : 32'hBAD0_0000 + 32'(k);
      bus1.mem_data_in = (k == 2) ? 32'h0000_0013 : 32'hBAD1_0000 + 32'(k);
      @(negedge clk);
      check("s1_gnt", 32'(bus.gnt),    (k <= 4) ? 32'd1 : 32'd0);
      check("s1_rd",  32'(bus.mem_rd), 32'(k == 1));
      check("s1_ack", 32'(bus.m0_ack), 32'(k == 4));
      if (k == 1) check("s1_addr",  bus.mem_addr, 32'hF000_0000);
      if (k == 3) check("s1_rdata", bus.m0_rdata, 32'h0000_0013);
      check("l1_gnt", 32'(bus1.gnt),    (k <= 3) ? 32'd1 : 32'd0);
      check("l1_rd",  32'(bus1.mem_rd), 32'(k == 1));
      check("l1_ack", 32'(bus1.m0_ack), 32'(k == 3));
      if (k == 2) check("l1_rdata", bus1.m0_rdata, 32'h0000_0013);
      if (k == 4) bus.m0_req = 1'b0;
      if (k == 3) bus1.m0_req = 1'b0;
    end

    // Scenario 2: m1 byte write leaves m0_rdata untouched.
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h0000_0100;
    bus.m1_wdata = 32'hAABB_CCDD; bus.m1_wmask = 4'b0010;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check("s2_wr",  32'(bus.mem_wr), 32'(k == 1));
      check("s2_ack", 32'(bus.m1_ack), 32'(k == 2));
      if (k == 1) begin
        check("s2_mask", 32'(bus.mem_wr_mask), 32'h2);
        check("s2_data", bus.mem_data_out, 32'hAABB_CCDD);
      end
      if (k == 2) bus.m1_req = 1'b0;
    end
    check("s2_m0_rdata", bus.m0_rdata, 32'h0000_0013);

    // Scenario 3: both masters hold reads; acks must alternate m0, m1, ...
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_1000;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_2000;
    n_ack = 0;
    for (int c = 0; c < 60 && n_ack < 4; c++) begin
      bus.mem_data_in = $urandom();
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) begin
        check("s3_order", 32'(bus.m1_ack), 32'(n_ack % 2));
        n_ack++;
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    check("s3_count", 32'(n_ack), 32'd4);

    // Scenario 4: reset during the WAIT state of an m1 read.
    do_reset();
    bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_0200; bus.mem_data_in = 32'h1234_5678;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("s4_gnt",   32'(bus.gnt),    32'd0);
    check("s4_busy",  32'(bus.busy),   32'd0);
    check("s4_rd",    32'(bus.mem_rd), 32'd0);
    check("s4_rdata", bus.m1_rdata,    32'd0);
    reset = 1'b0;
    bus.m1_req = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0000_0300;
    bus.mem_data_in = 32'h5555_AAAA;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("s4_m1_ack", 32'(bus.m1_ack), 32'd0);
      check("s4_m0_ack", 32'(bus.m0_ack), 32'(k == 4));
      if (k == 4) begin
        check("s4_m0_rdata", bus.m0_rdata, 32'h5555_AAAA);
        bus.m0_req = 1'b0;
      end
    end

    // Scenario 5: req kept high one cycle past ack starts a second read.
    bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0400;
    n_ack = 0;
    n_rd  = 0;
    for (int k = 0; k < 15; k++) begin
      bus.mem_data_in = $urandom();
      @(negedge clk);
      if (bus.mem_rd) n_rd++;
      if (bus.m0_ack) begin
        n_ack++;
        if (n_ack == 2) bus.m0_req = 1'b0;
      end
    end
    bus.m0_req = 1'b0;
    check("s5_rd_pulses", 32'(n_rd),  32'd2);
    check("s5_acks",      32'(n_ack), 32'd2);

    // Random phase, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      @(negedge clk);
    end
    reset = 1'b0;
    clear_inputs();
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single unified memory port between two bus masters: m0 (CPU core) and m1 (DMA/debug loader).
- Uses round-robin arbitration and runs one transaction at a time.
- Each master uses a level-request / single-cycle-ack handshake.
- Sequences the memory-side pulses (mem_rd/mem_wr) and waits a fixed read latency before returning data, so masters no longer hard-code memory delay stages.

Parameters:
- READ_LAT, 2, cycles from the mem_rd pulse to valid mem_data_in (minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  m0 transaction request (level)
- m0_we  in  1  m0 write (1) / read (0)
- m0_addr  in  32  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_wmask  in  4  m0 byte-lane write mask
- m0_ack  out  1  m0 transaction complete (1-cycle pulse)
- m0_rdata  out  32  m0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, m1_ack, m1_rdata: same as the m0 signals, for m1
- gnt  out  2  one-hot owner of the current transaction (00 when idle)
- busy  out  1  transaction in progress
- mem_addr  out  32  memory address
- mem_data_out  out  32  memory write data
- mem_wr_mask  out  4  byte-lane mask (0000 on reads)
- mem_wr  out  1  write strobe (1-cycle pulse)
- mem_rd  out  1  read strobe (1-cycle pulse)
- mem_data_in  in  32  memory read data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - mem_addr, mem_data_out, m0_rdata, m1_rdata = 0.
  - mem_wr_mask = 0000; mem_wr = mem_rd = 0.
  - m0_ack = m1_ack = 0; gnt = 00; busy = 0.
  - State = IDLE; round-robin pointer favours m0.
- Reset mid-transaction: the transaction is dropped, no ack is issued, and all outputs return to their reset values at the next edge.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the request lines.
  - If exactly one master requests, it wins. If both request, the master not granted last wins; the first conflict after reset goes to m0.
  - The winner's we/addr/wdata/wmask are latched; gnt and busy are set. Next state is ISSUE.
- ISSUE (exactly one cycle):
  - mem_rd = !we, mem_wr = we, both for this cycle only.
  - mem_addr and mem_data_out hold the latched values; mem_wr_mask = wmask on writes, 0000 on reads.
  - Write: next state is RESP.
  - Read: the wait counter loads READ_LAT-1 and next state is WAIT.
- WAIT:
  - Counts down. When the counter is 0, captures mem_data_in into the winner's rdata register and moves to RESP.
  - With READ_LAT=1, WAIT lasts one cycle, and the capture happens in the cycle after ISSUE.
- RESP:
  - The winner's ack = 1 for this cycle.
  - gnt = 00 and busy = 0 from the next cycle; next state is IDLE.
- Read timing (request first sampled in IDLE at cycle 0):
  - mem_rd in cycle 1.
  - Data captured in cycle 1+READ_LAT.
  - Ack and rdata visible in cycle 2+READ_LAT.
- Write timing: mem_wr in cycle 1, ack in cycle 2.
- Master rules:
  - Hold req and all request fields stable until ack is seen, then drop req at that same edge.
  - A req still high in the IDLE cycle after ack counts as a new request.
- mX_rdata holds its value until that master's next read completes. Writes and the other master's traffic do not disturb it.
- mem_addr, mem_data_out and mem_wr_mask keep the last transaction's values while idle.
- Request fields are ignored outside IDLE. Changing them mid-transaction has no effect.
- No address alignment checks; addresses pass through unmodified.
- Throughput: the fastest back-to-back write rate is one transaction every 3 cycles; the fastest read rate is one every 3+READ_LAT cycles.

Test Plan:
- Read with READ_LAT=2 → mem_rd high only in cycle 1 with mem_addr=0xF0000000.
  - Stimulus: after reset, m0 reads addr 0xF0000000; memory drives 0x00000013 in cycle 3.
  - Required: m0_ack in cycle 4; m0_rdata=0x00000013; gnt=01 in cycles 0–4 (0 = first IDLE edge).
- m1 byte write → write strobe and ack.
  - Stimulus: m1 writes addr 0x100, wdata 0xAABBCCDD, wmask 0010.
  - Required: mem_wr=1 for exactly one cycle with mem_wr_mask=0010 and mem_data_out=0xAABBCCDD; m1_ack two cycles after the request is sampled; m0_rdata unchanged.
- Contention → m0 served first (pointer after reset), then m1.
  - Stimulus: m0 and m1 hold reads continuously.
  - Required: grants alternate m0, m1, m0, m1; no master is granted twice in a row while the other waits.
- Reset mid-transaction → no acks, and the read does not complete.
  - Stimulus: assert reset in the WAIT state of an m1 read.
  - Required: next cycle gnt=00, busy=0, mem_rd=0, m1_rdata=0; the following read from m0 completes normally.
- Held request → new transaction, not a duplicate ack.
  - Stimulus: m0 keeps req high one cycle past ack.
  - Required: a second full transaction starts from IDLE, producing a second mem_rd pulse.
- READ_LAT=1 instance → one fewer cycle of latency.
  - Stimulus: repeat the first read scenario.
  - Required: ack in cycle 3; data captured in cycle 2.
